// File: rtl/grad_wb_pkg.sv
// Shared types and constants for the gradient write-back burst FIFO.
package grad_wb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } drain_state_t;

    typedef enum logic [1:0] {
        WATERMARK = 2'd0,
        TIMEOUT   = 2'd1,
        FLUSH     = 2'd2
    } burst_cause_t;

    localparam logic [31:0] WB_COUNT_SAT = 32'hFFFF_FFFF;

endpackage

// File: rtl/grad_wb_fifo_mem.sv
// Power-of-two FIFO storage with occupancy count; push and pop may coincide.
module grad_wb_fifo_mem
    import grad_wb_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // Stale contents are hidden so the head reads zero after reset or when drained.
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/grad_wb_burst_fifo.sv
// Write-back buffer draining {addr, value} entries to DRAM as bursts on watermark, timeout or flush.
module grad_wb_burst_fifo
    import grad_wb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int GRAD_W     = 32,
    parameter int DEPTH      = 32,
    parameter int BURST_SIZE = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic signed [GRAD_W-1:0] in_value,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic                     dram_valid,
    input  logic                     dram_ready,
    output logic [ADDR_W-1:0]        dram_addr,
    output logic signed [GRAD_W-1:0] dram_value,
    output logic                     dram_last,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     fifo_full,
    output logic                     draining,
    output logic [31:0]              burst_count
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  BURST_MAX  = CNT_W'(BURST_SIZE);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);

    drain_state_t              state, state_next;
    burst_cause_t              last_cause, cause_next;
    logic                      start_burst;
    logic [CNT_W-1:0]          burst_len;
    logic [CNT_W-1:0]          beat_cnt;
    logic [IDLE_W-1:0]         idle_cnt;
    logic                      flush_pending;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic [ADDR_W+GRAD_W-1:0]  head;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == WB_COUNT_SAT) ? v : v + 32'd1;
    endfunction

    grad_wb_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + GRAD_W)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({in_addr, in_value}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready   = !fifo_full && !flush_pending;
    assign push       = in_valid && in_ready;
    assign dram_valid = (state == BURST);
    assign draining   = dram_valid;
    assign pop        = dram_valid && dram_ready;
    assign dram_last  = dram_valid && (beat_cnt == burst_len - 1'b1);
    assign flush_done = flush_pending && (state == IDLE) && fifo_empty;
    assign dram_addr  = head[ADDR_W+GRAD_W-1:GRAD_W];
    assign dram_value = head[GRAD_W-1:0];

    always_comb begin
        state_next  = state;
        start_burst = 1'b0;
        cause_next  = WATERMARK;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    if (fifo_count >= BURST_MAX) begin
                        start_burst = 1'b1;
                        cause_next  = WATERMARK;
                    end else if (flush_pending) begin
                        start_burst = 1'b1;
                        cause_next  = FLUSH;
                    end else if (TIMEOUT != 0 && idle_cnt == IDLE_LIMIT) begin
                        start_burst = 1'b1;
                        cause_next  = grad_wb_pkg::TIMEOUT;
                    end
                end
                if (start_burst) state_next = BURST;
            end
            BURST: begin
                if (pop && dram_last) state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_cause    <= WATERMARK;
            burst_len     <= '0;
            beat_cnt      <= '0;
            idle_cnt      <= '0;
            flush_pending <= 1'b0;
            burst_count   <= '0;
        end else begin
            state <= state_next;
            // The burst length is frozen at start so later pushes wait for the next burst.
            if (start_burst) begin
                burst_len  <= (fifo_count >= BURST_MAX) ? BURST_MAX : fifo_count;
                beat_cnt   <= '0;
                last_cause <= cause_next;
            end else if (pop) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // Pushes deliberately do not restart the idle timer.
            if (state != IDLE || start_burst || fifo_empty)
                idle_cnt <= '0;
            else if (TIMEOUT != 0 && fifo_count < BURST_MAX)
                idle_cnt <= idle_cnt + 1'b1;
            if (flush_done)
                flush_pending <= 1'b0;
            else if (flush_req)
                flush_pending <= 1'b1;
            if (pop && dram_last)
                burst_count <= sat_inc(burst_count);
            if (dram_valid)
                assert ((last_cause == WATERMARK) == (burst_len == BURST_MAX));
        end
    end

endmodule

// File: tb/tb_grad_wb_burst_fifo.sv
// Randomised bench for grad_wb_burst_fifo against a queue-based behavioural model.
module tb_grad_wb_burst_fifo;

    localparam int ADDR_W     = 32;
    localparam int GRAD_W     = 32;
    localparam int DEPTH      = 32;
    localparam int BURST_SIZE = 16;
    localparam int TIMEOUT    = 64;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [ADDR_W-1:0]        in_addr = '0;
    logic signed [GRAD_W-1:0] in_value = '0;
    logic                     flush_req = 1'b0;
    logic                     flush_done;
    logic                     dram_valid;
    logic                     dram_ready = 1'b0;
    logic [ADDR_W-1:0]        dram_addr;
    logic signed [GRAD_W-1:0] dram_value;
    logic                     dram_last;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_full;
    logic                     draining;
    logic [31:0]              burst_count;

    grad_wb_burst_fifo #(
        .ADDR_W(ADDR_W), .GRAD_W(GRAD_W), .DEPTH(DEPTH),
        .BURST_SIZE(BURST_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_value(in_value),
        .flush_req(flush_req), .flush_done(flush_done),
        .dram_valid(dram_valid), .dram_ready(dram_ready), .dram_addr(dram_addr),
        .dram_value(dram_value), .dram_last(dram_last),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .draining(draining),
        .burst_count(burst_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic signed [GRAD_W-1:0] value;
    } ent_t;

    // Behavioural model: a queue of pending entries plus the current burst's remaining beats.
    ent_t        q[$];
    bit          m_burst = 0;
    bit          m_flush = 0;
    int          m_left = 0;
    int          m_age = 0;
    logic [31:0] m_bursts = '0;
    int          beat_in_burst = 0;
    int          lens[$];
    logic [31:0] last_addrs[$];
    int          done_pulses = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_update();
        int   sz;
        bit   take, pop, done, start;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_burst = 0; m_flush = 0; m_left = 0; m_age = 0;
            m_bursts = '0; beat_in_burst = 0;
            return;
        end
        sz    = q.size();
        take  = in_valid && (sz != DEPTH) && !m_flush;
        pop   = m_burst && dram_ready;
        done  = m_flush && !m_burst && (sz == 0);
        start = !m_burst && (sz > 0) &&
                (sz >= BURST_SIZE || m_flush || (TIMEOUT != 0 && m_age == TIMEOUT));
        if (!m_burst && !start && sz > 0 && sz < BURST_SIZE && TIMEOUT != 0) m_age++;
        else m_age = 0;
        if (pop) begin
            e = q.pop_front();
            m_left--;
            beat_in_burst++;
            if (m_left == 0) begin
                m_burst = 0;
                if (m_bursts != 32'hFFFF_FFFF) m_bursts++;
                lens.push_back(beat_in_burst);
                last_addrs.push_back(e.addr);
                beat_in_burst = 0;
            end
        end else if (start) begin
            m_burst = 1;
            m_left  = (sz < BURST_SIZE) ? sz : BURST_SIZE;
        end
        if (done) m_flush = 0;
        else if (flush_req) m_flush = 1;
        if (take) begin
            e.addr  = in_addr;
            e.value = in_value;
            q.push_back(e);
        end
    endtask

    task automatic compare();
        int                       sz;
        logic [ADDR_W-1:0]        ea;
        logic signed [GRAD_W-1:0] ev;
        sz = q.size();
        ea = (sz != 0) ? q[0].addr : '0;
        ev = (sz != 0) ? q[0].value : '0;
        chk("in_ready",    in_ready,    (sz != DEPTH) && !m_flush);
        chk("fifo_count",  fifo_count,  sz);
        chk("fifo_full",   fifo_full,   sz == DEPTH);
        chk("dram_valid",  dram_valid,  m_burst);
        chk("draining",    draining,    m_burst);
        chk("dram_last",   dram_last,   m_burst && m_left == 1);
        chk("flush_done",  flush_done,  m_flush && !m_burst && sz == 0);
        chk("dram_addr",   dram_addr,   ea);
        chk("dram_value",  dram_value,  ev);
        chk("burst_count", burst_count, m_bursts);
        if (flush_done) done_pulses++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic push_seq(input int n, input logic [31:0] base);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 2000) begin
            in_valid = 1'b1;
            in_addr  = base + 32'(i);
            in_value = i;
            acc = (q.size() != DEPTH) && !m_flush;
            tick();
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        chk("push_seq_done", i, n);
    endtask

    task automatic wait_empty(input int bound);
        int g = 0;
        while ((q.size() != 0 || m_burst || m_flush) && g < bound) begin
            tick();
            g++;
        end
        chk("drain_within_bound", g < bound, 1);
    endtask

    task automatic random_traffic(input int n);
        int acc_n = 0;
        int g = 0;
        bit acc;
        while (acc_n < n && g < 20000) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_addr    = $urandom;
            in_value   = ($urandom_range(0, 7) == 0) ? -32768 : $urandom;
            dram_ready = $urandom_range(0, 1);
            flush_req  = ($urandom_range(0, 199) == 0);
            acc = in_valid && (q.size() != DEPTH) && !m_flush;
            tick();
            if (acc) acc_n++;
            g++;
        end
        in_valid = 1'b0;
        flush_req = 1'b0;
        dram_ready = 1'b1;
        chk("rand_accepted", acc_n, n);
        wait_empty(500);
    endtask

    initial begin
        int t0;
        int g;

        // Reset values
        tick();
        tick();
        chk("rst_in_ready",    in_ready, 1);
        chk("rst_fifo_count",  fifo_count, 0);
        chk("rst_dram_valid",  dram_valid, 0);
        chk("rst_dram_addr",   dram_addr, 0);
        chk("rst_burst_count", burst_count, 0);
        chk("rst_flush_done",  flush_done, 0);
        rst_n = 1'b1;

        // Watermark burst of 16
        dram_ready = 1'b1;
        lens.delete(); last_addrs.delete();
        push_seq(16, 32'h1000);
        wait_empty(100);
        chk("wm_nbursts",    lens.size(), 1);
        chk("wm_len",        lens[0], 16);
        chk("wm_last_addr",  last_addrs[0], 32'h100F);
        chk("wm_burst_count", burst_count, 1);

        // Idle timeout on a partial burst of 5
        lens.delete();
        t0 = cyc + 1;
        push_seq(5, 32'h1800);
        g = 0;
        while (!dram_valid && g < 200) begin
            tick();
            g++;
        end
        chk("to_latency", cyc - t0, 65);
        wait_empty(100);
        chk("to_nbursts", lens.size(), 1);
        chk("to_len",     lens[0], 5);

        // Fill to full with DRAM stalled, then drain with more pushes arriving
        lens.delete();
        dram_ready = 1'b0;
        push_seq(32, 32'h2000);
        chk("full_flag",     fifo_full, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_count",    fifo_count, 32);
        dram_ready = 1'b1;
        push_seq(8, 32'h2020);
        wait_empty(300);
        chk("fill_nbursts", lens.size(), 3);
        chk("fill_len0",    lens[0], 16);
        chk("fill_len1",    lens[1], 16);
        chk("fill_len2",    lens[2], 8);

        // Flush with 20 entries queued
        lens.delete();
        dram_ready = 1'b0;
        push_seq(20, 32'h3000);
        done_pulses = 0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        dram_ready = 1'b1;
        wait_empty(200);
        chk("flush_nbursts", lens.size(), 2);
        chk("flush_len0",    lens[0], 16);
        chk("flush_len1",    lens[1], 4);
        chk("flush_pulses",  done_pulses, 1);

        // Flush on an empty FIFO
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        chk("empty_flush_done", flush_done, 1);
        tick();
        chk("empty_flush_clear", flush_done, 0);

        // Random traffic with random back-pressure
        random_traffic(1000);

        // Asynchronous reset in the middle of a burst, on its 7th beat
        dram_ready = 1'b1;
        push_seq(16, 32'h4000);
        g = 0;
        while (!(m_burst && beat_in_burst == 6) && g < 100) begin
            tick();
            g++;
        end
        chk("reach_beat7", g < 100, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dram_valid",  dram_valid, 0);
        chk("arst_fifo_count",  fifo_count, 0);
        chk("arst_burst_count", burst_count, 0);
        chk("arst_dram_last",   dram_last, 0);
        chk("arst_in_ready",    in_ready, 1);
        chk("arst_dram_addr",   dram_addr, 0);
        tick();
        rst_n = 1'b1;
        lens.delete();
        push_seq(3, 32'h5000);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        wait_empty(100);
        chk("post_rst_len",         lens[0], 3);
        chk("post_rst_burst_count", burst_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grad_wb_burst_fifo.md
# grad_wb_burst_fifo

Parametrised write-back buffer between the gradient accumulator's eviction/bypass path and DRAM. Accepts {address, value} write-back entries over a valid/ready handshake, stores them in a power-of-two FIFO, and drains them as bursts with a `dram_last` marker. Bursts start on a watermark, on an idle timeout, or on an explicit flush. This generalises the fixed FIFO_DEPTH/BURST_SIZE drain of the current accumulator with configurable widths, partial bursts, and a flush handshake.

## Interface
- ADDR_W, 32, address width
- GRAD_W, 32, value width (signed)
- DEPTH, 32, FIFO entries; power of two, ≥2
- BURST_SIZE, 16, maximum beats per burst; 1..DEPTH
- TIMEOUT, 64, IDLE cycles with 0 < count < BURST_SIZE before a partial burst starts; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  write-back entry valid
- in_ready  out  1  entry accepted when in_valid && in_ready
- in_addr  in  ADDR_W  entry address
- in_value  in  GRAD_W  entry value (signed)
- flush_req  in  1  one-cycle pulse requesting a full drain
- flush_done  out  1  one-cycle pulse when a requested drain completes
- dram_valid  out  1  beat valid
- dram_ready  in  1  beat consumed when dram_valid && dram_ready
- dram_addr  out  ADDR_W  head address
- dram_value  out  GRAD_W  head value
- dram_last  out  1  final beat of the current burst
- fifo_count  out  $clog2(DEPTH)+1  occupancy
- fifo_full  out  1  count == DEPTH
- draining  out  1  state is BURST
- burst_count  out  32  completed bursts; saturates at 2^32-1

## Operation
- in_ready = !fifo_full && !flush_pending. Both terms are registered, so there is no combinational path from in_valid to in_ready.
- States:
  - IDLE: dram_valid = 0.
  - BURST: dram_valid = 1 while beats remain.
- IDLE→BURST when count > 0 and any of the following holds:
  - count ≥ BURST_SIZE
  - flush_pending
  - idle_cnt == TIMEOUT (only when TIMEOUT ≠ 0)
- On that transition, latch burst_len = min(BURST_SIZE, count) and clear beat_cnt.
- In BURST, each handshake pops the head and increments beat_cnt.
- dram_last = dram_valid && (beat_cnt == burst_len−1).
- The handshake with dram_last returns the FSM to IDLE and increments burst_count.
- Partial bursts are legal (burst_len < BURST_SIZE). Entries pushed during a burst are not added to it.
- idle_cnt:
  - Increments in IDLE while 0 < count < BURST_SIZE.
  - Clears on count == 0, on leaving IDLE, and at reset.
  - Pushes do not clear it, so worst-case residency is bounded.
- flush_req sets flush_pending.
  - Bursts repeat back-to-back until count == 0 in IDLE.
  - Then flush_done pulses for one cycle and flush_pending clears.
  - flush_req while flush_pending is already set is ignored.
- Order is strict FIFO; no entry is dropped, merged or reordered.

## Timing
- Reset values:
  - in_ready = 1 (FIFO empty, no flush pending).
  - fifo_count = 0, fifo_full = 0, burst_count = 0.
  - dram_valid, dram_last, draining and flush_done = 0.
  - dram_addr and dram_value = 0.
  - State is IDLE; idle_cnt, pointers and flush_pending are 0.
- Push at edge N → fifo_count updates at N. The watermark is evaluated on the registered count: IDLE→BURST at N+1, and dram_valid is high after N+1.
- dram_addr and dram_value come from the head storage registers. They must stay stable while dram_valid && !dram_ready.
- Back-to-back beats at 1/cycle when dram_ready is held high. There is one IDLE cycle between consecutive bursts.
- A simultaneous push and pop leaves count unchanged. A push on the same cycle as the count reaching DEPTH−1 is still allowed.
- Pointers wrap modulo DEPTH.
- flush_req with an empty FIFO: flush_done pulses at the next edge.
- rst_n low at any time, including mid-burst: outputs return to reset values immediately (asynchronously), and FIFO contents are discarded.

## Structure
- Package grad_wb_pkg:
  - drain_state_t {IDLE, BURST}
  - burst_cause_t {WATERMARK, TIMEOUT, FLUSH}, used for debug/assertions
  - Constant WB_COUNT_SAT = 32'hFFFF_FFFF.
- Sub-module grad_wb_fifo_mem:
  - Parameters DEPTH and W = ADDR_W+GRAD_W.
  - Handles storage, read/write pointers, count and full/empty.
  - Push and pop may occur in the same cycle.
- The top level holds the drain FSM, beat/idle counters, flush logic and burst_count.

## Test plan
- DEPTH=32, BURST_SIZE=16, dram_ready=1; push 16 entries addr 0x1000+i, value i → one 16-beat burst in order, dram_last on addr 0x100F, burst_count=1.
- Push 5 entries, no further input, TIMEOUT=64 → a 5-beat burst starts 65 cycles after count first becomes nonzero, dram_last on beat 5.
- Push 40 entries while dram_ready=0 → in_ready drops at count 32 and value fields hold stable. Raising dram_ready then drains bursts of 16,16 plus the remainder, all in order with no loss.
- Push 20 entries, pulse flush_req → bursts of 16 then 4, in_ready low throughout, flush_done a single pulse after the last pop; flush_req on an empty FIFO → flush_done the next cycle.
- Toggle dram_ready randomly at 50% over 1000 entries with random values including −32768 → the output sequence equals the input sequence, and each burst has exactly one dram_last.
- Assert rst_n low mid-burst at beat 7 → dram_valid=0, fifo_count=0, burst_count=0 immediately; normal operation resumes after release.
